// File: rtl/pipe_stage_skid_v.sv
// rtl/pipe_stage_skid_v.sv - generic valid/ready pipeline stage with 2-entry skid buffer
// Optional stall/bubble counters are built only when PIPE_STATS_EN is defined.
module pipe_stage_skid_v #(
  parameter int DATA_W       = 32,
  parameter bit CLR_ON_FLUSH = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  state_t            state_q, state_d, st;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  // The unused encoding behaves exactly like EMPTY everywhere it is decoded.
  assign st        = (state_q == ST_BAD) ? ST_EMPTY : state_q;
  assign out_valid = (st != ST_EMPTY);
  assign in_ready  = (st != ST_FULL);
  assign out_data  = main_q;
  assign occupancy = st;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = st;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (st)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (in_fire && out_fire) begin
            main_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (stats_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end else if (!flush) begin
      if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (!out_valid && out_ready && (bubble_q != '1)) bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  logic stats_clr_unused;
  assign stats_clr_unused = stats_clr;
  assign stall_cnt        = '0;
  assign bubble_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_v.sv
// tb/tb_pipe_stage_skid_v.sv - scoreboard bench for pipe_stage_skid_v (stats checked when PIPE_STATS_EN)
module tb_pipe_stage_skid_v;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic          stats_clr = 1'b0;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_main = '0;
  int            m_stall = 0;
  int            m_bubble = 0;

  pipe_stage_skid_v #(.DATA_W(DW), .CLR_ON_FLUSH(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stats_clr(stats_clr),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted output must be the oldest accepted input.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got %0h expected nothing at %0t", out_data, $time);
      end else begin
        chk("out_order", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                     input logic fl, input logic clr, input logic rst);
    int  n;
    bit  ifire, ofire;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    stats_clr = clr;
    reset     = rst;
    @(negedge clk);
    n = m_q.size();
    chk("out_valid", out_valid, (n > 0));
    chk("in_ready", in_ready, (n < 2));
    chk("occupancy", occupancy, n);
    chk("out_data", out_data, m_main);
`ifdef PIPE_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("bubble_cnt", bubble_cnt, m_bubble);
`else
    chk("stall_cnt", stall_cnt, 0);
    chk("bubble_cnt", bubble_cnt, 0);
`endif
    @(posedge clk);
    ifire = iv && (n < 2);
    ofire = ordy && (n > 0);
    if (!rst) begin
      m_q.delete();
      exp_q.delete();
      m_main = '0;
      m_stall = 0;
      m_bubble = 0;
    end else begin
      if (clr) begin
        m_stall = 0;
        m_bubble = 0;
      end else if (!fl) begin
        if (n > 0 && !ordy && m_stall < (1 << CW) - 1) m_stall++;
        if (n == 0 && ordy && m_bubble < (1 << CW) - 1) m_bubble++;
      end
      if (fl) begin
        m_q.delete();
        exp_q.delete();
        m_main = '0;
      end else begin
        if (ofire) void'(m_q.pop_front());
        if (ifire) begin
          m_q.push_back(d);
          exp_q.push_back(d);
        end
        if (m_q.size() > 0) m_main = m_q[0];
      end
    end
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // 1: reset with an offered payload, then release
    cyc(1, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(1, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(1, 32'hDEADBEEF, 0, 0, 0, 1);
    cyc(0, 32'h0, 1, 0, 0, 1);
    chk("rst_release_data", out_data, 32'hDEADBEEF);
    cyc(0, 32'h0, 1, 0, 0, 1);
    // 2: streaming
    for (int i = 1; i <= 4; i++) cyc(1, i, 1, 0, 0, 1);
    cyc(0, 32'h0, 1, 0, 0, 1);
    cyc(0, 32'h0, 1, 0, 0, 1);
    // 3: back-pressure
    cyc(1, 32'h11, 0, 0, 0, 1);
    cyc(1, 32'h22, 0, 0, 0, 1);
    cyc(1, 32'h33, 0, 0, 0, 1);
    cyc(1, 32'h33, 0, 0, 0, 1);
    cyc(1, 32'h33, 1, 0, 0, 1);
    cyc(0, 32'h0, 1, 0, 0, 1);
    cyc(0, 32'h0, 1, 0, 0, 1);
    cyc(0, 32'h0, 1, 0, 0, 1);
    // 4: flush while FULL
    cyc(1, 32'hA1, 0, 0, 0, 1);
    cyc(1, 32'hA2, 0, 0, 0, 1);
    cyc(1, 32'h44, 0, 1, 0, 1);
    cyc(0, 32'h0, 1, 0, 0, 1);
    chk("flush_cleared_data", out_data, 32'h0);
    // 5: simultaneous in/out fire in ONE
    cyc(1, 32'h55, 0, 0, 0, 1);
    cyc(1, 32'h66, 1, 0, 0, 1);
    cyc(0, 32'h0, 0, 0, 0, 1);
    chk("swap_data", out_data, 32'h66);
    // 6: stall saturation, clear, bubbles
    for (int i = 0; i < 20; i++) cyc(0, 32'h0, 0, 0, 0, 1);
    cyc(0, 32'h0, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 6,
          $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 99) != 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0, 0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
